// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file at the WR stage: mtc0/mfc0, exception entry,
// eret redirect, the Count/Compare timer and the interrupt request.
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  wr_cp0op,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_wdata,
  input  logic [4:0]  rd_cs,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_badvaddr,
  input  logic [5:0]  hw_int,
  output logic        int_req,
  output logic [31:0] exc_pc_out,
  output logic        redirect
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;

  localparam logic [XLEN-1:0] STATUS_RST = 32'h0040_0000;
  localparam logic [2:0] OP_MTC0 = 3'b010;
  localparam logic [2:0] OP_ERET = 3'b011;

  localparam logic [4:0] CS_BADVADDR = 5'd8;
  localparam logic [4:0] CS_COUNT    = 5'd9;
  localparam logic [4:0] CS_COMPARE  = 5'd11;
  localparam logic [4:0] CS_STATUS   = 5'd12;
  localparam logic [4:0] CS_CAUSE    = 5'd13;
  localparam logic [4:0] CS_EPC      = 5'd14;

  logic [XLEN-1:0] badvaddr_q, badvaddr_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [4:0]      exc_code_q, exc_code_d;
  logic [1:0]      ip_sw_q, ip_sw_d;
  logic [5:0]      hw_q, hw_d;
  logic            ti_q, ti_d;
  logic            toggle_q, toggle_d;

  logic            do_exc, do_eret, do_mtc0;
  logic [XLEN-1:0] count_inc;
  logic [XLEN-1:0] cause;

  // Exception beats eret beats mtc0; mtc0 with sel!=0 is a no-op.
  assign do_exc    = exc_req;
  assign do_eret   = ~exc_req & (wr_cp0op == OP_ERET);
  assign do_mtc0   = ~exc_req & (wr_cp0op == OP_MTC0) & (wr_sel == 3'd0);
  assign count_inc = count_q + 32'd1;

  assign cause = {1'b0, ti_q, 14'd0, hw_q[5] | ti_q, hw_q[4:0], ip_sw_q,
                  1'b0, exc_code_q, 2'b00};

  assign int_req  = status_q[ST_IE] & ~status_q[ST_EXL]
                  & (|(cause[15:8] & status_q[15:8]));
  assign redirect = do_exc | do_eret;

  always_comb begin
    exc_pc_out = '0;
    if (do_exc) begin
      exc_pc_out = EXC_VECTOR;
    end else if (do_eret) begin
      exc_pc_out = epc_q;
    end
  end

  // mfc0 read port: pre-edge register values, no bypass.
  always_comb begin
    rd_data = '0;
    if (rd_sel == 3'd0) begin
      case (rd_cs)
        CS_BADVADDR: rd_data = badvaddr_q;
        CS_COUNT:    rd_data = count_q;
        CS_COMPARE:  rd_data = compare_q;
        CS_STATUS:   rd_data = status_q;
        CS_CAUSE:    rd_data = cause;
        CS_EPC:      rd_data = epc_q;
        default:     rd_data = '0;
      endcase
    end
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    hw_d       = hw_int;
    ti_d       = ti_q;
    toggle_d   = ~toggle_q;

    // Count advances every other cycle; a software write restarts the phase.
    if (do_mtc0 && wr_cs == CS_COUNT) begin
      count_d  = wr_wdata;
      toggle_d = 1'b0;
    end else if (toggle_q) begin
      count_d = count_inc;
      if (count_inc == compare_q) begin
        ti_d = 1'b1;
      end
    end

    if (do_mtc0) begin
      case (wr_cs)
        CS_COMPARE: begin
          compare_d = wr_wdata;
          ti_d      = 1'b0;
        end
        CS_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wr_wdata & STATUS_WMASK);
        CS_CAUSE:  ip_sw_d  = wr_wdata[9:8];
        CS_EPC:    epc_d    = wr_wdata;
        default:   ;
      endcase
    end

    if (do_exc) begin
      epc_d            = exc_epc;
      exc_code_d       = exc_code;
      status_d[ST_EXL] = 1'b1;
      if (exc_code == 5'd4 || exc_code == 5'd5) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (do_eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      hw_q       <= '0;
      ti_q       <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      hw_q       <= hw_d;
      ti_q       <= ti_d;
      toggle_q   <= toggle_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: a register-level model checked every cycle,
// plus literal expectations at each scenario step.
`timescale 1ns/1ps
module tb_cp0_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  wr_cp0op;
  logic [4:0]  wr_cs;
  logic [2:0]  wr_sel;
  logic [31:0] wr_wdata;
  logic [4:0]  rd_cs;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic [5:0]  hw_int;
  logic        int_req;
  logic [31:0] exc_pc_out;
  logic        redirect;

  cp0_regfile dut (
    .clk(clk), .rst(rst),
    .wr_cp0op(wr_cp0op), .wr_cs(wr_cs), .wr_sel(wr_sel), .wr_wdata(wr_wdata),
    .rd_cs(rd_cs), .rd_sel(rd_sel), .rd_data(rd_data),
    .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .hw_int(hw_int),
    .int_req(int_req), .exc_pc_out(exc_pc_out), .redirect(redirect)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  logic [4:0] rot [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};

  // Model state: Count is a base value plus half the edges since it was set.
  logic [31:0] m_status, m_epc, m_bva, m_cmp, m_cnt_base;
  int unsigned m_since;
  logic        m_ti;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [5:0]  m_hw;

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_since / 2);
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = 32'h0;
    c[30]    = m_ti;
    c[15]    = m_hw[5] | m_ti;
    c[14:10] = m_hw[4:0];
    c[9:8]   = m_ipsw;
    c[6:2]   = m_code;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] cs, input logic [2:0] sel);
    if (sel != 3'd0) return 32'h0;
    case (cs)
      5'd8:    return m_bva;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] old_c, new_c;
    logic n_ti;
    bit ex, er, mt;
    if (rst) begin
      m_status = 32'h0040_0000; m_epc = 0; m_bva = 0; m_cmp = 0; m_cnt_base = 0;
      m_since = 0; m_ti = 0; m_ipsw = 0; m_code = 0; m_hw = 0;
    end else begin
      ex = exc_req;
      er = !ex && wr_cp0op == 3'b011;
      mt = !ex && wr_cp0op == 3'b010 && wr_sel == 3'd0;
      n_ti = m_ti;
      old_c = m_count();
      if (mt && wr_cs == 5'd9) begin
        m_cnt_base = wr_wdata;
        m_since = 0;
      end else begin
        m_since = m_since + 1;
        new_c = m_count();
        if (new_c != old_c && new_c == m_cmp) n_ti = 1'b1;
      end
      if (mt && wr_cs == 5'd11) begin
        m_cmp = wr_wdata;
        n_ti = 1'b0;
      end
      if (mt && wr_cs == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (wr_wdata & 32'h0000_FF03);
      if (mt && wr_cs == 5'd13) m_ipsw = wr_wdata[9:8];
      if (mt && wr_cs == 5'd14) m_epc = wr_wdata;
      if (ex) begin
        m_epc = exc_epc;
        m_code = exc_code;
        m_status[1] = 1'b1;
        if (exc_code == 5'd4 || exc_code == 5'd5) m_bva = exc_badvaddr;
      end
      if (er) m_status[1] = 1'b0;
      m_hw = hw_int;
      m_ti = n_ti;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (chk_en) begin
      exp_pc = exc_req ? 32'h0000_4180 : (wr_cp0op == 3'b011 ? m_epc : 32'h0);
      chk("model rd_data", rd_data, m_read(rd_cs, rd_sel));
      chk("model int_req", 32'(int_req), 32'(m_int()));
      chk("model redirect", 32'(redirect), 32'(exc_req | (wr_cp0op == 3'b011)));
      chk("model exc_pc_out", exc_pc_out, exp_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_cp0op = 3'd0; wr_cs = 5'd0; wr_sel = 3'd0; wr_wdata = 32'h0;
    exc_req = 1'b0; exc_code = 5'd0; exc_epc = 32'h0; exc_badvaddr = 32'h0;
    cyc++;
    rd_cs  = rot[cyc % 8];
    rd_sel = (cyc % 5 == 0) ? 3'd1 : 3'd0;
  endtask

  task automatic chk_rd(input string nm, input logic [4:0] cs, input logic [2:0] sel,
                        input logic [31:0] exp);
    rd_cs = cs;
    rd_sel = sel;
    #1;
    chk(nm, rd_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] cs, input logic [2:0] sel, input logic [31:0] d);
    wr_cp0op = 3'b010; wr_cs = cs; wr_sel = sel; wr_wdata = d;
    tick();
  endtask

  task automatic eret(input logic [31:0] exp_pc);
    wr_cp0op = 3'b011;
    #1;
    chk("eret redirect", 32'(redirect), 32'h1);
    chk("eret pc", exc_pc_out, exp_pc);
    tick();
  endtask

  task automatic take_exc(input logic [4:0] code, input logic [31:0] epc,
                          input logic [31:0] bva, input bit with_eret);
    exc_req = 1'b1; exc_code = code; exc_epc = epc; exc_badvaddr = bva;
    if (with_eret) wr_cp0op = 3'b011;
    #1;
    chk("exc redirect", 32'(redirect), 32'h1);
    chk("exc pc", exc_pc_out, 32'h0000_4180);
    tick();
  endtask

  initial begin
    rst = 1'b1; hw_int = 6'd0; rd_cs = 5'd0; rd_sel = 3'd0;
    wr_cp0op = 3'd0; wr_cs = 5'd0; wr_sel = 3'd0; wr_wdata = 32'h0;
    exc_req = 1'b0; exc_code = 5'd0; exc_epc = 32'h0; exc_badvaddr = 32'h0;
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;

    chk_rd("reset status", 5'd12, 3'd0, 32'h0040_0000);
    chk_rd("reset epc", 5'd14, 3'd0, 32'h0);
    chk("reset int_req", 32'(int_req), 32'h0);
    chk("reset redirect", 32'(redirect), 32'h0);

    mtc0(5'd14, 3'd0, 32'h0000_1234);
    chk_rd("mtc0 epc", 5'd14, 3'd0, 32'h0000_1234);
    eret(32'h0000_1234);
    chk_rd("eret status", 5'd12, 3'd0, 32'h0040_0000);

    take_exc(5'd4, 32'h0000_2000, 32'h0000_0FFF, 1'b0);
    chk_rd("exc4 epc", 5'd14, 3'd0, 32'h0000_2000);
    chk_rd("exc4 badvaddr", 5'd8, 3'd0, 32'h0000_0FFF);
    chk_rd("exc4 status", 5'd12, 3'd0, 32'h0040_0002);
    chk_rd("exc4 cause", 5'd13, 3'd0, 32'h0000_0010);

    take_exc(5'd5, 32'h0000_3000, 32'h0000_0ABC, 1'b1);
    chk_rd("exc+eret status", 5'd12, 3'd0, 32'h0040_0002);
    chk_rd("exc5 badvaddr", 5'd8, 3'd0, 32'h0000_0ABC);
    chk_rd("exc5 epc", 5'd14, 3'd0, 32'h0000_3000);

    take_exc(5'd8, 32'h0000_3004, 32'h0000_5555, 1'b0);
    chk_rd("exc8 badvaddr kept", 5'd8, 3'd0, 32'h0000_0ABC);
    chk_rd("exc8 cause", 5'd13, 3'd0, 32'h0000_0020);
    eret(32'h0000_3004);
    chk_rd("eret clears exl", 5'd12, 3'd0, 32'h0040_0000);

    mtc0(5'd12, 3'd0, 32'h0000_8001);
    chk_rd("status masked", 5'd12, 3'd0, 32'h0040_8001);
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9, 3'd0, 32'd0);
    repeat (9) tick();
    chk_rd("timer count 4", 5'd9, 3'd0, 32'd4);
    chk("timer int_req early", 32'(int_req), 32'h0);
    tick();
    chk_rd("timer count 5", 5'd9, 3'd0, 32'd5);
    chk_rd("timer cause ti", 5'd13, 3'd0, 32'h4000_8020);
    chk("timer int_req", 32'(int_req), 32'h1);
    tick();
    chk("timer holds", 32'(int_req), 32'h1);
    mtc0(5'd11, 3'd0, 32'h0000_0100);
    chk_rd("compare clears ti", 5'd13, 3'd0, 32'h0000_0020);
    chk("compare clears int", 32'(int_req), 32'h0);

    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    chk_rd("wrap e0", 5'd9, 3'd0, 32'hFFFF_FFFF);
    tick();
    chk_rd("wrap e1", 5'd9, 3'd0, 32'hFFFF_FFFF);
    tick();
    chk_rd("wrap e2", 5'd9, 3'd0, 32'h0);

    mtc0(5'd14, 3'd1, 32'h0000_DEAD);
    chk_rd("sel1 epc unchanged", 5'd14, 3'd0, 32'h0000_3004);
    chk_rd("sel1 read zero", 5'd14, 3'd1, 32'h0);
    chk_rd("cs15 read zero", 5'd15, 3'd0, 32'h0);
    mtc0(5'd8, 3'd0, 32'h0000_1111);
    chk_rd("badvaddr read-only", 5'd8, 3'd0, 32'h0000_0ABC);

    hw_int = 6'b000100;
    mtc0(5'd12, 3'd0, 32'h0000_1001);
    chk_rd("hw status", 5'd12, 3'd0, 32'h0040_1001);
    chk_rd("hw cause", 5'd13, 3'd0, 32'h0000_1020);
    chk("hw int_req", 32'(int_req), 32'h1);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    chk_rd("cause sw ip", 5'd13, 3'd0, 32'h0000_1320);
    hw_int = 6'b000000;
    tick();
    chk_rd("hw drop cause", 5'd13, 3'd0, 32'h0000_0320);
    chk("sw ip masked", 32'(int_req), 32'h0);

    hw_int = 6'b100000;
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    chk_rd("ip7 hw cause", 5'd13, 3'd0, 32'h0000_8320);
    chk("ip7 int_req", 32'(int_req), 32'h1);
    take_exc(5'd0, 32'h0000_0040, 32'h0, 1'b0);
    chk("exl masks int", 32'(int_req), 32'h0);
    hw_int = 6'b000000;

    exc_req = 1'b1; exc_code = 5'd4; exc_epc = 32'h0000_7777; exc_badvaddr = 32'h0000_8888;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rd("rst status", 5'd12, 3'd0, 32'h0040_0000);
    chk_rd("rst epc", 5'd14, 3'd0, 32'h0);
    chk_rd("rst cause", 5'd13, 3'd0, 32'h0);
    chk_rd("rst badvaddr", 5'd8, 3'd0, 32'h0);
    chk_rd("rst compare", 5'd11, 3'd0, 32'h0);
    chk_rd("rst count", 5'd9, 3'd0, 32'h0);
    chk("rst int_req", 32'(int_req), 32'h0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
